// File: rtl/vector_writeback_queue.sv
// Buffers completed vector results and writes them to the vector register file one at
// a time, handshaking on rf_status; also flags RAW hazards against buffered writes.
module vector_writeback_queue #(
    parameter int LEN         = 32,
    parameter int VECTOR_SIZE = 8,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_rd,
    input  logic                       in_vm,
    input  logic [VECTOR_SIZE*LEN-1:0] in_mask,
    input  logic [VECTOR_SIZE*LEN-1:0] in_data,
    input  logic [LEN-1:0]             in_length,
    input  logic [2:0]                 in_data_type,
    output logic [1:0]                 rf_signal,
    output logic [4:0]                 rf_rd,
    output logic                       rf_vm,
    output logic [VECTOR_SIZE*LEN-1:0] rf_mask,
    output logic [VECTOR_SIZE*LEN-1:0] rf_data,
    output logic [LEN-1:0]             rf_length,
    output logic [2:0]                 rf_data_type,
    output logic                       write_back_enabled,
    input  logic [1:0]                 rf_status,
    input  logic [4:0]                 chk_rs1,
    input  logic [4:0]                 chk_rs2,
    input  logic [4:0]                 chk_rs3,
    output logic                       hazard,
    output logic                       mask_hazard,
    output logic                       empty
);

    localparam int VW    = VECTOR_SIZE * LEN;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [1:0] VECTOR_RF_WRITE = 2'b01;
    localparam logic [1:0] RF_FINISHED     = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]     rd;
        logic           vm;
        logic [VW-1:0]  mask;
        logic [VW-1:0]  data;
        logic [LEN-1:0] length;
        logic [2:0]     data_type;
    } entry_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           fifo_q [FIFO_DEPTH];
    entry_t           fifo_d [FIFO_DEPTH];

    entry_t           in_entry;
    entry_t           head_entry;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] slot_off;
    logic             slot_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    always_comb begin
        in_entry.rd        = in_rd;
        in_entry.vm        = in_vm;
        in_entry.mask      = in_mask;
        in_entry.data      = in_data;
        in_entry.length    = in_length;
        in_entry.data_type = in_data_type;
    end

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        in_ready = (count_q < CNT_FULL) && rdy_in && !rst;
        push     = in_valid && in_ready;
        pop      = rdy_in && (state_q == WAIT) && (rf_status == RF_FINISHED);
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        fifo_d  = fifo_q;

        if (rdy_in) begin
            case (state_q)
                IDLE:    if (count_q != '0) state_d = ISSUE;
                ISSUE:   state_d = WAIT;
                WAIT:    if (pop) state_d = (count_q > CNT_ONE) ? ISSUE : IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (push) begin
            fifo_d[tail_q] = in_entry;
            tail_d         = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked solely by head/count.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_comb begin
        head_entry         = fifo_q[head_q];
        write_back_enabled = (state_q == ISSUE);
        rf_signal          = write_back_enabled ? VECTOR_RF_WRITE : 2'b00;
        rf_rd              = '0;
        rf_vm              = 1'b0;
        rf_mask            = '0;
        rf_data            = '0;
        rf_length          = '0;
        rf_data_type       = '0;
        if (state_q != IDLE) begin
            rf_rd        = head_entry.rd;
            rf_vm        = head_entry.vm;
            rf_mask      = head_entry.mask;
            rf_data      = head_entry.data;
            rf_length    = head_entry.length;
            rf_data_type = head_entry.data_type;
        end
        empty = (count_q == '0);
    end

    // The in-flight head stays occupied until its pop, so it still raises hazards.
    always_comb begin
        hazard      = 1'b0;
        mask_hazard = 1'b0;
        slot_off    = '0;
        slot_used   = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot_off  = PTR_W'(i) - head_q;
            slot_used = CNT_W'(slot_off) < count_q;
            if (slot_used) begin
                if (fifo_q[i].rd == chk_rs1 || fifo_q[i].rd == chk_rs2 ||
                    fifo_q[i].rd == chk_rs3)
                    hazard = 1'b1;
                if (fifo_q[i].rd == 5'd0)
                    mask_hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vector_writeback_queue.sv
// Bench for vector_writeback_queue: scenario tasks plus a queue-based reference
// model and a register-file responder that answers each committed strobe.
module tb_vector_writeback_queue;

    localparam int LEN   = 32;
    localparam int VS    = 8;
    localparam int DEPTH = 2;
    localparam int VW    = LEN * VS;

    localparam logic [1:0] WR  = 2'b01;
    localparam logic [1:0] FIN = 2'b01;
    localparam logic [1:0] NOP = 2'b00;
    localparam logic [2:0] FOUR_BYTE = 3'd2;

    typedef struct packed {
        logic [4:0]     rd;
        logic           vm;
        logic [VW-1:0]  mask;
        logic [VW-1:0]  data;
        logic [LEN-1:0] length;
        logic [2:0]     dt;
    } ent_t;

    logic           clk, rst, rdy_in, in_valid, in_ready, in_vm;
    logic [4:0]     in_rd;
    logic [VW-1:0]  in_mask, in_data;
    logic [LEN-1:0] in_length;
    logic [2:0]     in_data_type;
    logic [1:0]     rf_signal, rf_status;
    logic [4:0]     rf_rd;
    logic           rf_vm;
    logic [VW-1:0]  rf_mask, rf_data;
    logic [LEN-1:0] rf_length;
    logic [2:0]     rf_data_type;
    logic           write_back_enabled;
    logic [4:0]     chk_rs1, chk_rs2, chk_rs3;
    logic           hazard, mask_hazard, empty;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_push = 0;
    int resp_cnt = -1;
    int rf_delay = 0;
    int last_commit = -10;
    bit stale_fin = 0;
    bit resp_fin = 0;
    bit mon_en = 0;
    bit strobe_commit = 0;

    ent_t       mq [$];
    logic [4:0] strobe_rd [$];
    int         strobe_cyc [$];

    vector_writeback_queue #(.LEN(LEN), .VECTOR_SIZE(VS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_vm(in_vm),
        .in_mask(in_mask), .in_data(in_data), .in_length(in_length),
        .in_data_type(in_data_type),
        .rf_signal(rf_signal), .rf_rd(rf_rd), .rf_vm(rf_vm), .rf_mask(rf_mask),
        .rf_data(rf_data), .rf_length(rf_length), .rf_data_type(rf_data_type),
        .write_back_enabled(write_back_enabled), .rf_status(rf_status),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rs3(chk_rs3),
        .hazard(hazard), .mask_hazard(mask_hazard), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of accepted entries, checked every cycle.
    always begin : monitor
        ent_t obs, inent;
        bit exp_rdy, exp_empty, exp_haz, exp_mh, push_now, pop_now;
        logic [4:0] exp_rd;
        @(negedge clk);
        strobe_commit = 0;
        push_now = 0;
        pop_now = 0;
        if (mon_en) begin
            exp_rdy   = (mq.size() < DEPTH) && rdy_in && !rst;
            exp_empty = (mq.size() == 0);
            exp_haz   = 0;
            exp_mh    = 0;
            foreach (mq[i]) begin
                if (mq[i].rd == chk_rs1 || mq[i].rd == chk_rs2 || mq[i].rd == chk_rs3) exp_haz = 1;
                if (mq[i].rd == 5'd0) exp_mh = 1;
            end
            total += 4;
            if (in_ready !== exp_rdy) begin bad++; $display("FAIL mon_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
            if (empty !== exp_empty) begin bad++; $display("FAIL mon_empty cyc=%0d got=%b exp=%b", cyc, empty, exp_empty); end
            if (hazard !== exp_haz) begin bad++; $display("FAIL mon_hazard cyc=%0d got=%b exp=%b", cyc, hazard, exp_haz); end
            if (mask_hazard !== exp_mh) begin bad++; $display("FAIL mon_mask_hazard cyc=%0d got=%b exp=%b", cyc, mask_hazard, exp_mh); end

            obs = '{rd: rf_rd, vm: rf_vm, mask: rf_mask, data: rf_data, length: rf_length, dt: rf_data_type};
            exp_rd = (mq.size() > 0) ? mq[0].rd : 5'd0;
            if (write_back_enabled === 1'b1 && rdy_in && !rst) begin
                strobe_commit = 1;
                total += 2;
                if (mq.size() == 0 || resp_cnt >= 0 || last_commit == cyc - 1 || obs !== mq[0]) begin
                    bad++;
                    $display("FAIL mon_strobe cyc=%0d got_rd=%0d exp_rd=%0d qsize=%0d", cyc, rf_rd, exp_rd, mq.size());
                end
                if (rf_signal !== WR) begin bad++; $display("FAIL mon_rf_signal cyc=%0d got=%b exp=%b", cyc, rf_signal, WR); end
                strobe_rd.push_back(rf_rd);
                strobe_cyc.push_back(cyc);
                last_commit = cyc;
            end else if (mq.size() == 0) begin
                total++;
                if (write_back_enabled !== 1'b0 || rf_signal !== 2'b00 || obs !== '0) begin
                    bad++;
                    $display("FAIL mon_idle_outputs cyc=%0d wbe=%b sig=%b rd=%0d exp=all-zero", cyc, write_back_enabled, rf_signal, rf_rd);
                end
            end
            push_now = in_valid && exp_rdy;
            inent = '{rd: in_rd, vm: in_vm, mask: in_mask, data: in_data, length: in_length, dt: in_data_type};
            pop_now = resp_fin && (rf_status == FIN) && rdy_in && !rst && (mq.size() > 0);
        end
        @(posedge clk);
        cyc++;
        if (mon_en) begin
            if (rst) mq.delete();
            else begin
                if (pop_now) void'(mq.pop_front());
                if (push_now) begin mq.push_back(inent); n_push++; end
            end
        end
    end

    // One clock step; afterwards plays the register file's reply to a committed strobe.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            resp_cnt = -1; resp_fin = 0; rf_status = NOP;
        end else if (rdy_in) begin
            if (strobe_commit) resp_cnt = rf_delay;
            if (resp_cnt == 0) begin
                rf_status = FIN; resp_fin = 1; resp_cnt = -1;
            end else begin
                rf_status = stale_fin ? FIN : NOP;
                resp_fin = 0;
                if (resp_cnt > 0) resp_cnt--;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 0;
        while (mq.size() > 0 && n < 200) begin tick(); n++; end
    endtask

    task automatic set_entry(input logic [4:0] rd);
        in_rd = rd;
        in_vm = 1'($urandom);
        for (int w = 0; w < VS; w++) begin
            in_mask[w*LEN +: LEN] = $urandom;
            in_data[w*LEN +: LEN] = $urandom;
        end
        in_length    = LEN'($urandom_range(0, 16));
        in_data_type = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        rst = 1; rdy_in = 1; in_valid = 0; rf_status = NOP;
        chk_rs1 = 5'd30; chk_rs2 = 5'd30; chk_rs3 = 5'd30;
        set_entry(5'd0);
        tick(); tick();
        mon_en = 1;
        rst = 0;
        #1;
        total += 4;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
        if (hazard !== 1'b0 || mask_hazard !== 1'b0) begin bad++; $display("FAIL rst_hazards got=%b%b exp=00", hazard, mask_hazard); end
        if (write_back_enabled !== 1'b0 || rf_signal !== 2'b00 || rf_rd !== 5'd0) begin
            bad++; $display("FAIL rst_outputs wbe=%b sig=%b rd=%0d exp=0", write_back_enabled, rf_signal, rf_rd);
        end
    endtask

    task automatic test_single();
        rf_delay = 0;
        in_rd = 5'd5; in_vm = 1; in_mask = '0; in_data = '0;
        in_data[63:0] = 64'h0807060504030201;
        in_length = 8; in_data_type = FOUR_BYTE;
        in_valid = 1;
        tick();                                   // E0: push
        in_valid = 0;
        total++;
        if (write_back_enabled !== 1'b0 || empty !== 1'b0) begin bad++; $display("FAIL single_e0 wbe=%b empty=%b exp wbe=0 empty=0", write_back_enabled, empty); end
        tick();                                   // E1: strobe starts
        total += 2;
        if (write_back_enabled !== 1'b1 || rf_signal !== WR || rf_rd !== 5'd5) begin
            bad++; $display("FAIL single_strobe wbe=%b sig=%b rd=%0d exp 1/01/5", write_back_enabled, rf_signal, rf_rd);
        end
        if (rf_data[63:0] !== 64'h0807060504030201 || rf_length !== 8 || rf_data_type !== FOUR_BYTE || rf_vm !== 1'b1) begin
            bad++; $display("FAIL single_fields data=%h len=%0d dt=%0d", rf_data[63:0], rf_length, rf_data_type);
        end
        tick();                                   // E2: commit, now waiting
        total++;
        if (write_back_enabled !== 1'b0 || rf_rd !== 5'd5 || empty !== 1'b0) begin bad++; $display("FAIL single_wait wbe=%b rd=%0d empty=%b exp 0/5/0", write_back_enabled, rf_rd, empty); end
        tick();                                   // E3: pop
        total++;
        if (empty !== 1'b1 || rf_rd !== 5'd0) begin bad++; $display("FAIL single_pop empty=%b rd=%0d exp 1/0", empty, rf_rd); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (write_back_enabled !== 1'b0) begin bad++; $display("FAIL single_no_extra wbe=%b exp=0", write_back_enabled); end
        end
    endtask

    task automatic test_back_to_back();
        int s0 = strobe_rd.size();
        int n = 0;
        rf_delay = 0;
        set_entry(5'd1); in_valid = 1;
        tick();                                   // E0
        set_entry(5'd2);
        tick();                                   // E1: queue full
        set_entry(5'd3);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_a got=%b exp=0", in_ready); end
        tick();                                   // E2
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_b got=%b exp=0", in_ready); end
        tick();                                   // E3: first pop
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_resume got=%b exp=1", in_ready); end
        tick();                                   // E4: third push
        in_valid = 0;
        while (strobe_rd.size() < s0 + 3 && n < 40) begin tick(); n++; end
        total++;
        if (strobe_rd.size() != s0 + 3) begin
            bad++; $display("FAIL b2b_count got=%0d exp=3", strobe_rd.size() - s0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (strobe_rd[s0+i] !== 5'(i + 1)) begin bad++; $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", i, strobe_rd[s0+i], i + 1); end
            end
            for (int i = 1; i < 3; i++) begin
                total++;
                if (strobe_cyc[s0+i] - strobe_cyc[s0+i-1] != 2) begin
                    bad++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=2", i, strobe_cyc[s0+i] - strobe_cyc[s0+i-1]);
                end
            end
        end
        drain();
    endtask

    task automatic test_hazard();
        rf_delay = 3;
        chk_rs2 = 5'd7;
        set_entry(5'd7); in_valid = 1;
        tick();
        in_valid = 0;
        total++;
        if (hazard !== 1'b1 || mask_hazard !== 1'b0) begin bad++; $display("FAIL haz_set got=%b%b exp=10", hazard, mask_hazard); end
        drain();
        total++;
        if (hazard !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL haz_clear hazard=%b empty=%b exp 0/1", hazard, empty); end
        set_entry(5'd0); in_valid = 1;
        tick();
        in_valid = 0;
        total++;
        if (mask_hazard !== 1'b1) begin bad++; $display("FAIL mask_haz_set got=%b exp=1", mask_hazard); end
        chk_rs2 = 5'd30;
        drain();
    endtask

    task automatic test_withhold();
        rf_delay = 10;
        set_entry(5'd9); in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        total++;
        if (write_back_enabled !== 1'b1) begin bad++; $display("FAIL hold_strobe got=%b exp=1", write_back_enabled); end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (write_back_enabled !== 1'b0 || rf_rd !== 5'd9 || empty !== 1'b0) begin
                bad++; $display("FAIL hold_wait i=%0d wbe=%b rd=%0d empty=%b exp 0/9/0", i, write_back_enabled, rf_rd, empty);
            end
        end
        drain();
        total++;
        if (empty !== 1'b1) begin bad++; $display("FAIL hold_drain empty=%b exp=1", empty); end
        stale_fin = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (write_back_enabled !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL stale_fin wbe=%b empty=%b exp 0/1", write_back_enabled, empty); end
        end
        stale_fin = 0;
        tick();
    endtask

    task automatic test_reset_wait();
        int s0;
        rf_delay = 20;
        set_entry(5'd4); in_valid = 1;
        tick();
        set_entry(5'd6);
        tick();
        in_valid = 0;
        tick(); tick();
        total++;
        if (write_back_enabled !== 1'b0 || empty !== 1'b0 || rf_rd !== 5'd4) begin
            bad++; $display("FAIL rstw_pre wbe=%b empty=%b rd=%0d exp 0/0/4", write_back_enabled, empty, rf_rd);
        end
        s0 = strobe_rd.size();
        rst = 1;
        tick();
        rst = 0;
        #1;
        total++;
        if (write_back_enabled !== 1'b0 || empty !== 1'b1 || rf_signal !== 2'b00 || rf_rd !== 5'd0) begin
            bad++; $display("FAIL rstw_post wbe=%b empty=%b sig=%b rd=%0d exp 0/1/00/0", write_back_enabled, empty, rf_signal, rf_rd);
        end
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (strobe_rd.size() != s0) begin bad++; $display("FAIL rstw_no_strobe got=%0d exp=0", strobe_rd.size() - s0); end
    endtask

    task automatic test_freeze();
        int s0;
        rf_delay = 0;
        set_entry(5'd11); in_valid = 1;
        tick();
        in_valid = 0;
        tick();                                   // now issuing
        s0 = strobe_rd.size();
        rdy_in = 0;
        set_entry(5'd12); in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (write_back_enabled !== 1'b1 || rf_signal !== WR || rf_rd !== 5'd11 || in_ready !== 1'b0 || empty !== 1'b0) begin
                bad++; $display("FAIL freeze i=%0d wbe=%b sig=%b rd=%0d rdy=%b empty=%b", i, write_back_enabled, rf_signal, rf_rd, in_ready, empty);
            end
        end
        in_valid = 0;
        rdy_in = 1;
        tick();
        total++;
        if (write_back_enabled !== 1'b0 || rf_rd !== 5'd11) begin bad++; $display("FAIL freeze_resume wbe=%b rd=%0d exp 0/11", write_back_enabled, rf_rd); end
        drain();
        total++;
        if (strobe_rd.size() != s0 + 1 || empty !== 1'b1) begin
            bad++; $display("FAIL freeze_once strobes=%0d empty=%b exp 1/1", strobe_rd.size() - s0, empty);
        end
    endtask

    task automatic test_random();
        int s0 = strobe_rd.size();
        int p0 = n_push;
        for (int i = 0; i < 400; i++) begin
            set_entry(5'($urandom_range(0, 31)));
            in_valid = 1'($urandom_range(0, 1));
            rdy_in   = ($urandom_range(0, 9) != 0);
            rf_delay = $urandom_range(0, 3);
            chk_rs1  = 5'($urandom_range(0, 31));
            chk_rs2  = 5'($urandom_range(0, 31));
            chk_rs3  = 5'($urandom_range(0, 31));
            tick();
        end
        rdy_in = 1;
        drain();
        total++;
        if (empty !== 1'b1 || strobe_rd.size() - s0 != n_push - p0) begin
            bad++; $display("FAIL rand_drain empty=%b strobes=%0d pushes=%0d", empty, strobe_rd.size() - s0, n_push - p0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hazard();
        test_withhold();
        test_reset_wait();
        test_freeze();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
